// File: rtl/mem_editor.sv
// mem_editor: push-button memory inspect/edit controller.
//
// Four raw active-low buttons are synchronised, debounced and optionally
// auto-repeated into one-cycle command events. The controller then steps an
// address pointer or increments/decrements the addressed word held in an
// external synchronous single-port RAM (1-cycle read latency).
//
// Ports:
//   clk       : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   KEY[3:0]  : raw active-low buttons (0: data+1, 1: data-1, 2: addr+1, 3: addr-1)
//   ram_a     : RAM address (always equals addr)
//   ram_din   : RAM write data (always equals data)
//   ram_we    : RAM write enable, high only in WRITE
//   ram_dout  : RAM read data, valid the cycle after ram_a is presented
//   addr      : current pointer, for display
//   data      : word at addr, for display
//   busy      : high while not IDLE; key events are dropped while high
module mem_editor #(
  parameter int AW              = 4,
  parameter int DW              = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    KEY,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          busy
);

  // Debounce counter counts 0 .. DEBOUNCE_CYCLES-1; the flip happens on the
  // edge where it would reach DEBOUNCE_CYCLES.
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // Hold counter shared by the initial delay and the repeat period.
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {FETCH, LATCH, IDLE, WRITE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] data_nx;
  logic [3:0]    key_evt;

  // ---------------------------------------------------------------------------
  // Per-key front end: synchroniser, debouncer, press/repeat event generator.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [1:0]     key_sync;
    logic           pressed_raw;
    logic           deb;
    logic           press_evt;
    logic [DBW-1:0] db_cnt;

    // Synchroniser resets to the released level so no spurious press is seen.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) key_sync <= 2'b11;
      else          key_sync <= {key_sync[0], KEY[k]};
    end

    assign pressed_raw = ~key_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb       <= 1'b0;
        db_cnt    <= '0;
        press_evt <= 1'b0;
      end else begin
        press_evt <= 1'b0;
        if (pressed_raw == deb) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          deb       <= pressed_raw;
          db_cnt    <= '0;
          press_evt <= pressed_raw;  // pulse only on released -> pressed
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end
    end

    if (REPEAT_DELAY > 0) begin : g_rep
      logic [HW-1:0] hold_cnt;
      logic [HW-1:0] hold_last;
      logic          in_rate;
      logic          rep_evt;

      // hold_cnt is 0 in the press-event cycle, so the first repeat lands
      // exactly REPEAT_DELAY cycles later, then every REPEAT_RATE cycles.
      assign hold_last = in_rate ? RATE_LAST : DELAY_LAST;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hold_cnt <= '0;
          in_rate  <= 1'b0;
          rep_evt  <= 1'b0;
        end else if (!deb) begin
          hold_cnt <= '0;
          in_rate  <= 1'b0;
          rep_evt  <= 1'b0;
        end else if (hold_cnt == hold_last) begin
          hold_cnt <= '0;
          in_rate  <= 1'b1;
          rep_evt  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
          rep_evt  <= 1'b0;
        end
      end

      assign key_evt[k] = press_evt | rep_evt;
    end else begin : g_norep
      assign key_evt[k] = press_evt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM.
  // NOTE: the external RAM is deliberately never cleared; only the pointer,
  // the displayed word and the state are reset, then address 0 is refetched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      data  <= data_nx;
    end
  end

  // Fixed priority KEY[0] > KEY[1] > KEY[2] > KEY[3]; losers and any event
  // arriving outside IDLE are simply discarded.
  // NOTE: every output of this block is given a default first so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    data_nx  = data;
    case (state)
      FETCH: state_nx = LATCH;
      LATCH: begin
        data_nx  = ram_dout;
        state_nx = IDLE;
      end
      IDLE: begin
        if (key_evt[0]) begin
          data_nx  = data + DW'(1);
          state_nx = WRITE;
        end else if (key_evt[1]) begin
          data_nx  = data - DW'(1);
          state_nx = WRITE;
        end else if (key_evt[2]) begin
          addr_nx  = addr + AW'(1);
          state_nx = FETCH;
        end else if (key_evt[3]) begin
          addr_nx  = addr - AW'(1);
          state_nx = FETCH;
        end
      end
      WRITE:   state_nx = IDLE;
      default: state_nx = FETCH;
    endcase
  end

  // Decoded from the state register so reset drops ram_we asynchronously.
  assign ram_we  = (state == WRITE);
  assign busy    = (state != IDLE);
  assign ram_a   = addr;
  assign ram_din = data;

endmodule

// File: tb/tb_mem_editor.sv
// Self-checking bench for mem_editor: a behavioural RAM model, a write
// scoreboard (expected writes queued at stimulus time, popped when the DUT
// writes), and per-cycle logs of DUT outputs compared to hand-derived values.
module tb_mem_editor;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    KEY;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          busy;

  mem_editor #(
    .AW(AW), .DW(DW), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .KEY(KEY),
    .ram_a(ram_a), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .addr(addr), .data(data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, old data on read-during-write.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_din;
    ram_dout <= mem[ram_a];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  n_writes    = 0;

  logic          busy_log [64];
  logic          we_log   [64];
  logic [AW-1:0] addr_log [64];
  logic [DW-1:0] data_log [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every DUT write must match the head of the scoreboard.
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (reset_n && ram_we) begin
      n_writes++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed addr %0h din %0h expected no write", ram_a, ram_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(ram_a), 32'(e.a));
        chk("write_data", 32'(ram_din), 32'(e.d));
      end
    end
  end

  // Caller is at the start of cycle 0 (#1 after a rising edge). Drives keys,
  // releases them at the start of cycle 'hold', and logs outputs mid-cycle.
  task automatic run_key(input logic [3:0] keys, input int hold, input int total);
    KEY = keys;
    for (int c = 0; c < total; c++) begin
      if (c == hold) KEY = 4'hF;
      @(negedge clk);
      busy_log[c] = busy;
      we_log[c]   = ram_we;
      addr_log[c] = addr;
      data_log[c] = data;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int count_we(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(we_log[i]);
    return s;
  endfunction

  initial begin
    int n0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'(i * 17 + 3);
    mem[0]  = 8'h3C;
    mem[15] = 8'hA5;
    reset_n = 1'b0;
    KEY     = 4'hF;

    // Reset values.
    @(negedge clk);
    chk("rst_busy",    32'(busy),    32'd1);
    chk("rst_addr",    32'(addr),    32'd0);
    chk("rst_data",    32'(data),    32'd0);
    chk("rst_ram_we",  32'(ram_we),  32'd0);
    chk("rst_ram_a",   32'(ram_a),   32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);

    // Release: FETCH, LATCH, then IDLE with mem[0].
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_key(4'hF, 0, 3);
    chk("boot_busy0", 32'(busy_log[0]), 32'd1);
    chk("boot_busy1", 32'(busy_log[1]), 32'd1);
    chk("boot_busy2", 32'(busy_log[2]), 32'd0);
    chk("boot_data",  32'(data_log[2]), 32'h3C);
    chk("boot_addr",  32'(addr_log[2]), 32'd0);

    // Glitch of 3 cycles: no event.
    n0 = n_writes;
    run_key(4'b1110, 3, 12);
    chk("glitch_we",     32'(count_we(12)),   32'd0);
    chk("glitch_writes", 32'(n_writes - n0),  32'd0);
    chk("glitch_busy",   32'(busy_log[11]),   32'd0);

    // KEY[0] held: event at cycle 6, WRITE of 0x3D at cycle 7.
    exp_q.push_back('{a: 4'h0, d: 8'h3D});
    run_key(4'b1110, 6, 16);
    chk("inc_we6",   32'(we_log[6]),   32'd0);
    chk("inc_busy6", 32'(busy_log[6]), 32'd0);
    chk("inc_we7",   32'(we_log[7]),   32'd1);
    chk("inc_data7", 32'(data_log[7]), 32'h3D);
    chk("inc_we8",   32'(we_log[8]),   32'd0);
    chk("inc_busy8", 32'(busy_log[8]), 32'd0);
    chk("inc_count", 32'(count_we(16)), 32'd1);
    chk("inc_mem0",  32'(mem[0]),      32'h3D);

    // Address wrap down: 0 -> F, mem[15] shown after FETCH/LATCH.
    mem[0] = 8'hFF;
    run_key(4'b0111, 6, 16);
    chk("dec_addr6",  32'(addr_log[6]), 32'h0);
    chk("dec_addr7",  32'(addr_log[7]), 32'hF);
    chk("dec_busy7",  32'(busy_log[7]), 32'd1);
    chk("dec_busy8",  32'(busy_log[8]), 32'd1);
    chk("dec_busy9",  32'(busy_log[9]), 32'd0);
    chk("dec_data9",  32'(data_log[9]), 32'hA5);

    // Address wrap up: F -> 0, picks up mem[0]=0xFF.
    run_key(4'b1011, 6, 16);
    chk("wrapup_addr", 32'(addr_log[9]), 32'h0);
    chk("wrapup_data", 32'(data_log[9]), 32'hFF);

    // Data wrap: 0xFF+1 -> 0x00, then 0x00-1 -> 0xFF.
    exp_q.push_back('{a: 4'h0, d: 8'h00});
    run_key(4'b1110, 6, 16);
    chk("wrapinc_data", 32'(data_log[7]), 32'h00);
    exp_q.push_back('{a: 4'h0, d: 8'hFF});
    run_key(4'b1101, 6, 16);
    chk("wrapdec_data", 32'(data_log[7]), 32'hFF);
    chk("wrapdec_mem0", 32'(mem[0]),      32'hFF);

    // Auto-repeat: debounced hold spans cycles 6..35 -> event + 7 repeats.
    run_key(4'b1011, 30, 44);
    chk("rep_addr7",  32'(addr_log[7]),  32'h1);
    chk("rep_addr16", 32'(addr_log[16]), 32'h1);
    chk("rep_addr17", 32'(addr_log[17]), 32'h2);
    chk("rep_addr43", 32'(addr_log[43]), 32'h8);
    chk("rep_data43", 32'(data_log[43]), 32'h8B);

    // KEY[0] and KEY[2] together: only the data increment is taken.
    n0 = n_writes;
    exp_q.push_back('{a: 4'h8, d: 8'h8C});
    run_key(4'b1010, 6, 16);
    chk("both_addr",   32'(addr_log[15]),  32'h8);
    chk("both_data",   32'(data_log[15]),  32'h8C);
    chk("both_writes", 32'(n_writes - n0), 32'd1);

    // Reset pulsed during WRITE (KEY[1] at addr 8).
    run_key(4'b1101, 6, 7);
    chk("rw_we_before",  32'(ram_we),  32'd1);
    chk("rw_din_before", 32'(ram_din), 32'h8B);
    reset_n = 1'b0;
    #1;
    chk("rw_we_reset",   32'(ram_we), 32'd0);
    chk("rw_addr_reset", 32'(addr),   32'd0);
    chk("rw_busy_reset", 32'(busy),   32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_key(4'hF, 0, 3);
    chk("rw_busy0", 32'(busy_log[0]), 32'd1);
    chk("rw_busy1", 32'(busy_log[1]), 32'd1);
    chk("rw_busy2", 32'(busy_log[2]), 32'd0);
    chk("rw_data2", 32'(data_log[2]), 32'hFF);
    chk("rw_addr2", 32'(addr_log[2]), 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
